// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : uart_tx
// Description : Asynchronous serial transmitter. It is driven by the 16x
//               oversampling strobe from the baud generator and sends one
//               frame per load: a start bit, DATA_BITS data bits LSB first,
//               an optional even-parity bit, then STOP_BITS stop bits.
//
// Parameters  : DATA_BITS   data bits per frame (5..8)
//               STOP_BITS   stop bits per frame (1 or 2)
//
// Ports       : clock        global clock, all state updates on its rising edge
//               reset        synchronous active-high reset
//               ce_16        one-clock enable pulse at 16x the baud rate
//               tx_data      word to send, sampled only in the load cycle
//               new_tx_data  one-clock load strobe, ignored while tx_busy=1
//               tx_busy      high from the cycle after load to end of frame
//               ser_out      serial line, idles high
//
// Options     : define UART_TX_PARITY_EN to insert an even-parity bit after
//               the last data bit. When it is undefined the parity state and
//               its logic do not exist.
//
// Revision    : 1.0 - initial release
//==============================================================================
module uart_tx #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ce_16,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 new_tx_data,
   output logic                 tx_busy,
   output logic                 ser_out
);

   // Bit counter is 4 bits so that it can hold DATA_BITS = 8 without wrapping.
   localparam logic [3:0] c_data_bits = 4'(DATA_BITS);
   // Index of the final stop bit; the stop phase reuses the bit counter.
   localparam logic [3:0] c_stop_last = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT   = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd5
   } state_e;

   //---------------------------------------------------------------------------
   // Registered state
   //---------------------------------------------------------------------------
   state_e               r_state;
   logic                 r_ser_out;
   logic                 r_tx_busy;
   logic [DATA_BITS-1:0] r_shift;
   logic [3:0]           r_os_cnt;
   logic [3:0]           r_bit_cnt;
`ifdef UART_TX_PARITY_EN
   logic                 r_parity;
`endif

   //---------------------------------------------------------------------------
   // Next-state values
   //---------------------------------------------------------------------------
   state_e               w_state_nx;
   logic                 w_ser_out_nx;
   logic                 w_tx_busy_nx;
   logic [DATA_BITS-1:0] w_shift_nx;
   logic [3:0]           w_os_cnt_nx;
   logic [3:0]           w_bit_cnt_nx;
`ifdef UART_TX_PARITY_EN
   logic                 w_parity_nx;
`endif

   // One bit time has elapsed when the oversample counter wraps 15 -> 0.
   logic w_bit_done;
   assign w_bit_done = ce_16 && (r_os_cnt == 4'd15);

   // Shift register with zero fill into the vacated top bit.
   logic [DATA_BITS-1:0] w_shift_right;
   assign w_shift_right = {1'b0, r_shift[DATA_BITS-1:1]};

   //---------------------------------------------------------------------------
   // Next-state and output logic
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nx   = r_state;
      w_ser_out_nx = r_ser_out;
      w_tx_busy_nx = r_tx_busy;
      w_shift_nx   = r_shift;
      w_os_cnt_nx  = r_os_cnt;
      w_bit_cnt_nx = r_bit_cnt;
`ifdef UART_TX_PARITY_EN
      w_parity_nx  = r_parity;
`endif

      // The oversample counter runs only while a bit is on the line; in WAIT
      // it stays at zero so the start bit gets a full 16 pulses after its edge.
      if (ce_16 && (r_state != S_IDLE) && (r_state != S_WAIT)) begin
         w_os_cnt_nx = r_os_cnt + 4'd1;
      end

      case (r_state)
         S_IDLE: begin
            w_ser_out_nx = 1'b1;
            w_tx_busy_nx = 1'b0;
            if (new_tx_data && !r_tx_busy) begin
               w_shift_nx   = tx_data;
               w_os_cnt_nx  = 4'd0;
               w_bit_cnt_nx = 4'd0;
               w_tx_busy_nx = 1'b1;
               w_state_nx   = S_WAIT;
`ifdef UART_TX_PARITY_EN
               // Parity is frozen from the loaded word, so later changes
               // on tx_data cannot disturb the frame in flight.
               w_parity_nx  = ^tx_data;
`endif
            end
         end

         S_WAIT: begin
            // Start edge lands on the ce_16 grid.
            if (ce_16) begin
               w_ser_out_nx = 1'b0;
               w_state_nx   = S_START;
            end
         end

         S_START: begin
            if (w_bit_done) begin
               w_ser_out_nx = r_shift[0];
               w_shift_nx   = w_shift_right;
               w_bit_cnt_nx = 4'd1;
               w_state_nx   = S_DATA;
            end
         end

         S_DATA: begin
            if (w_bit_done) begin
               if (r_bit_cnt < c_data_bits) begin
                  w_ser_out_nx = r_shift[0];
                  w_shift_nx   = w_shift_right;
                  w_bit_cnt_nx = r_bit_cnt + 4'd1;
               end else begin
`ifdef UART_TX_PARITY_EN
                  w_ser_out_nx = r_parity;
                  w_state_nx   = S_PARITY;
`else
                  w_ser_out_nx = 1'b1;
                  w_bit_cnt_nx = 4'd0;
                  w_state_nx   = S_STOP;
`endif
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_bit_done) begin
               w_ser_out_nx = 1'b1;
               w_bit_cnt_nx = 4'd0;
               w_state_nx   = S_STOP;
            end
         end
`endif

         S_STOP: begin
            // Bit counter here counts completed stop bits.
            if (w_bit_done) begin
               if (r_bit_cnt == c_stop_last) begin
                  w_tx_busy_nx = 1'b0;
                  w_bit_cnt_nx = 4'd0;
                  w_state_nx   = S_IDLE;
               end else begin
                  w_bit_cnt_nx = r_bit_cnt + 4'd1;
               end
            end
         end

         default: begin
            w_ser_out_nx = 1'b1;
            w_tx_busy_nx = 1'b0;
            w_os_cnt_nx  = 4'd0;
            w_bit_cnt_nx = 4'd0;
            w_state_nx   = S_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ser_out <= 1'b1;
         r_tx_busy <= 1'b0;
         r_shift   <= '0;
         r_os_cnt  <= 4'd0;
         r_bit_cnt <= 4'd0;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nx;
         r_ser_out <= w_ser_out_nx;
         r_tx_busy <= w_tx_busy_nx;
         r_shift   <= w_shift_nx;
         r_os_cnt  <= w_os_cnt_nx;
         r_bit_cnt <= w_bit_cnt_nx;
`ifdef UART_TX_PARITY_EN
         r_parity  <= w_parity_nx;
`endif
      end
   end

   assign ser_out = r_ser_out;
   assign tx_busy = r_tx_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_uart_tx
// Description : Directed self-checking bench for uart_tx. ce_16 pulses every
//               4 clocks, so each bit lasts 64 clocks. Outputs are sampled
//               on the falling clock edge.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_uart_tx;

   localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
   localparam int P_BITS    = 1;
   localparam int STOP_BITS = 2;
`else
   localparam int P_BITS    = 0;
   localparam int STOP_BITS = 1;
`endif
   localparam int NBITS = 1 + DATA_BITS + P_BITS + STOP_BITS;

   logic       clock       = 1'b0;
   logic       reset       = 1'b1;
   logic       ce_16       = 1'b0;
   logic [7:0] tx_data     = 8'h00;
   logic       new_tx_data = 1'b0;
   logic       tx_busy;
   logic       ser_out;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx #(
      .DATA_BITS (DATA_BITS),
      .STOP_BITS (STOP_BITS)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ce_16       (ce_16),
      .tx_data     (tx_data),
      .new_tx_data (new_tx_data),
      .tx_busy     (tx_busy),
      .ser_out     (ser_out)
   );

   always #5 clock = ~clock;

   // ce_16: one pulse every 4 clocks, driven on the falling edge.
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(negedge clock);
         ce_16 = (ph == 3);
         ph = (ph + 1) % 4;
      end
   end

   // Watchdog
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Expected line levels of a frame, element 0 = start bit.
   function automatic logic [15:0] exp_frame(input logic [7:0] d);
      logic [15:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < DATA_BITS; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
      f[1+DATA_BITS] = ^d;
`endif
      return f;
   endfunction

   task automatic load_word(input logic [7:0] d);
      @(negedge clock);
      tx_data     = d;
      new_tx_data = 1'b1;
      @(negedge clock);
      new_tx_data = 1'b0;
   endtask

   // Waits for the start edge, then records the line at the first and last
   // clock of every bit, whether busy stayed high, and the state one clock
   // after the nominal end of the frame.
   task automatic capture_frame(output bit found, output int waited,
                                output logic [15:0] first, output logic [15:0] last,
                                output logic busy_hi, output logic end_ser,
                                output logic end_busy);
      found = 0; waited = 0; first = '0; last = '0;
      busy_hi = 1'b1; end_ser = 1'b0; end_busy = 1'b1;
      while (!found && waited < 200) begin
         @(negedge clock);
         waited++;
         if (ser_out === 1'b0) found = 1;
      end
      if (!found) return;
      for (int t = 0; t < 64*NBITS; t++) begin
         if (t > 0) @(negedge clock);
         if (t % 64 == 0)  first[t/64] = ser_out;
         if (t % 64 == 63) last[t/64]  = ser_out;
         if (tx_busy !== 1'b1) busy_hi = 1'b0;
      end
      @(negedge clock);
      end_ser  = ser_out;
      end_busy = tx_busy;
   endtask

   //---------------------------------------------------------------------------
   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_tests++;
         if (ser_out !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: ser_out=%b tx_busy=%b, expected 1/0", i, ser_out, tx_busy);
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         n_tests++;
         if (ser_out !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: ser_out=%b tx_busy=%b, expected 1/0", i, ser_out, tx_busy);
         end
      end
   endtask

   task automatic test_basic_frame();
      bit found; int waited; logic [15:0] first, last, exp;
      logic busy_hi, end_ser, end_busy;
      exp = exp_frame(8'h55);
      load_word(8'h55);
      capture_frame(found, waited, first, last, busy_hi, end_ser, end_busy);
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL basic_start: no start bit within %0d clocks, expected one", waited);
         return;
      end
      n_tests++;
      if (first[NBITS-1:0] !== exp[NBITS-1:0]) begin
         n_fail++;
         $display("FAIL basic_bits_first: got %b, expected %b", first[NBITS-1:0], exp[NBITS-1:0]);
      end
      n_tests++;
      if (last[NBITS-1:0] !== exp[NBITS-1:0]) begin
         n_fail++;
         $display("FAIL basic_bits_last: got %b, expected %b", last[NBITS-1:0], exp[NBITS-1:0]);
      end
      n_tests++;
      if (busy_hi !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_busy_frame: busy dropped during frame, expected high");
      end
      n_tests++;
      if (end_busy !== 1'b0 || end_ser !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_end: busy=%b ser=%b at frame end, expected 0/1", end_busy, end_ser);
      end
   endtask

   task automatic test_busy_reject();
      bit found; int waited; logic [15:0] first, last, exp;
      logic busy_hi, end_ser, end_busy, idle_ok;
      exp = exp_frame(8'hA3);
      load_word(8'hA3);
      fork
         capture_frame(found, waited, first, last, busy_hi, end_ser, end_busy);
         begin
            repeat (9) @(negedge clock);
            tx_data = 8'hFF; new_tx_data = 1'b1;
            @(negedge clock);
            new_tx_data = 1'b0;
            repeat (289) @(negedge clock);
            tx_data = 8'hFF; new_tx_data = 1'b1;
            @(negedge clock);
            new_tx_data = 1'b0;
         end
      join
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL reject_start: no start bit within %0d clocks, expected one", waited);
         return;
      end
      n_tests++;
      if (first[NBITS-1:0] !== exp[NBITS-1:0] || last[NBITS-1:0] !== exp[NBITS-1:0]) begin
         n_fail++;
         $display("FAIL reject_bits: got %b/%b, expected %b", first[NBITS-1:0], last[NBITS-1:0], exp[NBITS-1:0]);
      end
      n_tests++;
      if (busy_hi !== 1'b1 || end_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reject_busy: busy_hi=%b end_busy=%b, expected 1/0", busy_hi, end_busy);
      end
      idle_ok = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (ser_out !== 1'b1 || tx_busy !== 1'b0) idle_ok = 1'b0;
      end
      n_tests++;
      if (idle_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL reject_idle: line not idle after single frame, got activity, expected idle");
      end
   endtask

   task automatic test_back_to_back();
      bit found; int waited; logic [15:0] first, last, exp;
      logic busy_hi, end_ser, end_busy;
      load_word(8'h3C);
      capture_frame(found, waited, first, last, busy_hi, end_ser, end_busy);
      n_tests++;
      if (!found || end_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_first: found=%b end_busy=%b, expected 1/0", found, end_busy);
         return;
      end
      // First cycle with tx_busy low: strobe right now.
      tx_data = 8'h0F; new_tx_data = 1'b1;
      @(negedge clock);
      new_tx_data = 1'b0;
      exp = exp_frame(8'h0F);
      capture_frame(found, waited, first, last, busy_hi, end_ser, end_busy);
      n_tests++;
      if (!found || waited != 3) begin
         n_fail++;
         $display("FAIL b2b_latency: found=%b start after %0d clocks, expected 3", found, waited);
         if (!found) return;
      end
      n_tests++;
      if (first[NBITS-1:0] !== exp[NBITS-1:0] || last[NBITS-1:0] !== exp[NBITS-1:0]) begin
         n_fail++;
         $display("FAIL b2b_bits: got %b/%b, expected %b", first[NBITS-1:0], last[NBITS-1:0], exp[NBITS-1:0]);
      end
      n_tests++;
      if (busy_hi !== 1'b1 || end_busy !== 1'b0 || end_ser !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_end: busy_hi=%b end_busy=%b end_ser=%b, expected 1/0/1", busy_hi, end_busy, end_ser);
      end
   endtask

   // A strobe in the last busy cycle (same cycle busy falls) is dropped.
   task automatic test_late_strobe();
      bit found; int waited; logic idle_ok;
      load_word(8'h5A);
      found = 0; waited = 0;
      while (!found && waited < 200) begin
         @(negedge clock);
         waited++;
         if (ser_out === 1'b0) found = 1;
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL late_start: no start bit within %0d clocks, expected one", waited);
         return;
      end
      repeat (64*NBITS - 1) @(negedge clock);
      n_tests++;
      if (tx_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL late_busy_last: tx_busy=%b, expected 1", tx_busy);
      end
      tx_data = 8'h00; new_tx_data = 1'b1;
      @(negedge clock);
      new_tx_data = 1'b0;
      idle_ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (ser_out !== 1'b1 || tx_busy !== 1'b0) idle_ok = 1'b0;
         @(negedge clock);
      end
      n_tests++;
      if (idle_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL late_strobe: strobe accepted while busy falling, got activity, expected idle");
      end
   endtask

   task automatic test_reset_midframe();
      bit found; int waited; logic [15:0] first, last, exp;
      logic busy_hi, end_ser, end_busy;
      load_word(8'h00);
      found = 0; waited = 0;
      while (!found && waited < 200) begin
         @(negedge clock);
         waited++;
         if (ser_out === 1'b0) found = 1;
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL midrst_start: no start bit within %0d clocks, expected one", waited);
         return;
      end
      // Middle of data bit 4 (line position 5).
      repeat (64*5 + 20) @(negedge clock);
      n_tests++;
      if (ser_out !== 1'b0 || tx_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre: ser=%b busy=%b, expected 0/1", ser_out, tx_busy);
      end
      reset = 1'b1;
      @(negedge clock);
      n_tests++;
      if (ser_out !== 1'b1 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_post: ser=%b busy=%b, expected 1/0", ser_out, tx_busy);
      end
      reset = 1'b0;
      exp = exp_frame(8'h81);
      load_word(8'h81);
      capture_frame(found, waited, first, last, busy_hi, end_ser, end_busy);
      n_tests++;
      if (!found || first[NBITS-1:0] !== exp[NBITS-1:0] || last[NBITS-1:0] !== exp[NBITS-1:0]
          || busy_hi !== 1'b1 || end_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_frame: found=%b bits=%b/%b busy=%b/%b, expected %b busy 1/0",
                  found, first[NBITS-1:0], last[NBITS-1:0], busy_hi, end_busy, exp[NBITS-1:0]);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      bit found; int waited; logic [15:0] first, last, exp;
      logic busy_hi, end_ser, end_busy;
      logic [7:0] words [2];
      logic       pbit  [2];
      words[0] = 8'h07; pbit[0] = 1'b1;
      words[1] = 8'h03; pbit[1] = 1'b0;
      for (int w = 0; w < 2; w++) begin
         exp = exp_frame(words[w]);
         load_word(words[w]);
         capture_frame(found, waited, first, last, busy_hi, end_ser, end_busy);
         n_tests++;
         if (!found) begin
            n_fail++;
            $display("FAIL parity_start[%0d]: no start bit, expected one", w);
         end else begin
            n_tests++;
            if (first[1+DATA_BITS] !== pbit[w] || last[1+DATA_BITS] !== pbit[w]) begin
               n_fail++;
               $display("FAIL parity_bit[%0d]: got %b/%b, expected %b", w,
                        first[1+DATA_BITS], last[1+DATA_BITS], pbit[w]);
            end
            n_tests++;
            if (first[NBITS-1:0] !== exp[NBITS-1:0] || last[NBITS-1:0] !== exp[NBITS-1:0]
                || busy_hi !== 1'b1 || end_busy !== 1'b0) begin
               n_fail++;
               $display("FAIL parity_frame[%0d]: bits=%b/%b busy=%b/%b, expected %b busy 1/0", w,
                        first[NBITS-1:0], last[NBITS-1:0], busy_hi, end_busy, exp[NBITS-1:0]);
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_frame();
      test_busy_reject();
      test_back_to_back();
      test_late_strobe();
      test_reset_midframe();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      repeat (4) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
